vc_credit_arbiter: RTL and testbench
====================================

# vc_credit_arbiter

Round-robin scheduler sharing one valid/credit link among N_REQ valid/ready requesters. It tracks downstream credits (the receiver's buffer slots, one credit returned per slot freed) and issues a beat only when a credit is held. Arbitration is packet-atomic: a granted requester keeps the link until its last beat. It sits upstream of the team's valid/credit → valid/ready converter, whose FIFO depth equals CREDIT_NUM.

## Interface
- N_REQ, 4: number of requesters, ≥2.
- DATA_WIDTH, 8: beat width.
- CREDIT_NUM, 2: credits held after reset; must equal downstream buffer depth.
- Reset rst_n, synchronous, active-low; clock clk.
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_data_i  in  N_REQ*DATA_WIDTH  requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_valid_i  in  N_REQ  per-requester valid.
- req_last_i  in  N_REQ  marks final beat of a packet.
- req_ready_o  out  N_REQ  one-hot-or-zero accept.
- m_data_o  out  DATA_WIDTH  link data.
- m_valid_o  out  1  link valid, one-cycle pulse per beat.
- m_credit_i  in  1  one credit returned per high cycle.
- credit_cnt_o  out  $clog2(CREDIT_NUM+1)  credits currently held.
- cred_ovf_o  out  1  sticky: a credit arrived with the counter full.

## Operation
- can_send = (cnt != 0). Credits returned in the current cycle are not usable until the next cycle; there is no bypass.
- States:
  - IDLE (no lock). Winner = first valid requester scanning from ptr upward, mod N_REQ.
  - LOCKED (owner = lock_idx). Only the owner may be granted; other requesters are ignored even if valid.
- Grant: req_ready_o[w] = can_send && req_valid_i[w] for the current winner/owner. All other ready bits are 0. Ready is combinational from valid and cnt.
- Send = any req_ready_o && req_valid_i.
- On send:
  - ptr ← w+1 mod N_REQ.
  - If req_last_i[w]: go to or stay in IDLE.
  - Otherwise: go to LOCKED with lock_idx = w.
- While LOCKED, the owner's valid may drop between beats. The lock is held and other requesters stay blocked.
- Credit counter: cnt_next = cnt − send + m_credit_i.
  - A send and a credit in the same cycle leave cnt unchanged.
  - A credit with cnt == CREDIT_NUM and no send saturates the counter and sets cred_ovf_o. cred_ovf_o clears only on reset.
  - cnt never underflows, because a send requires cnt ≥ 1.
- Width of cnt: $clog2(CREDIT_NUM+1) bits, unsigned.

## Timing
- Reset values:
  - m_valid_o = 0, m_data_o = 0.
  - credit_cnt_o = CREDIT_NUM, cred_ovf_o = 0.
  - ptr = 0, state IDLE.
  - req_ready_o = 0 only while cnt = 0 or no valid is present.
- Latency: a beat accepted at edge t appears as m_valid_o = 1 with data in the cycle after t. m_data_o is registered and holds its last value when not sending.
- Throughput: one beat per cycle while credits remain. With continuous traffic, sustained rate = CREDIT_NUM beats per round-trip credit loop.
- credit_cnt_o reflects the registered count, updated on the edge of the send or credit.
- Reset mid-operation:
  - The lock is dropped and the counter reloads to CREDIT_NUM.
  - An in-flight beat is lost.
  - The downstream block must be reset in the same cycle.

## Test plan
- Reset, CREDIT_NUM=2, all four requesters valid with last=1, no credit returns → grants go 0, then 1. req_ready_o = 0 afterwards and credit_cnt_o = 0. m_valid_o pulses on the 2 cycles after each accept.
- Same setup, with m_credit_i pulsed once per cycle after the first two sends → grant order 0,1,2,3,0. Each beat's data matches its source on m_data_o one cycle later.
- Requester 2 sends a 3-beat packet (last on beat 3) with a 1-cycle valid gap, while requesters 0, 1, 3 are valid → only requester 2 is granted until its last beat. Next grant goes to 3.
- Send and m_credit_i in the same cycle with cnt=1 → cnt stays at 1 and the next cycle may send again.
- m_credit_i=1 at cnt=2 with no send → cnt stays 2 and cred_ovf_o = 1, remaining 1 until rst_n = 0.
- Assert rst_n=0 for one cycle while LOCKED on requester 1 with cnt=0 → next cycle: IDLE, cnt=2, m_valid_o=0, cred_ovf_o=0. Requester 0 then wins if valid.

Source files
------------

// File: rtl/vc_credit_arbiter_if.sv
// vc_credit_arbiter_if: requester-side valid/ready bundle plus the credit-controlled link
interface vc_credit_arbiter_if #(
   parameter int N_REQ      = 4,
   parameter int DATA_WIDTH = 8,
   parameter int CREDIT_NUM = 2
);
   localparam int CW = $clog2(CREDIT_NUM + 1);
   logic [N_REQ*DATA_WIDTH-1:0] req_data;
   logic [N_REQ-1:0]            req_valid;
   logic [N_REQ-1:0]            req_last;
   logic [N_REQ-1:0]            req_ready;
   logic [DATA_WIDTH-1:0]       m_data;
   logic                        m_valid;
   logic                        m_credit;
   logic [CW-1:0]               credit_cnt;
   logic                        cred_ovf;
   modport master (
      output req_data, req_valid, req_last, m_credit,
      input  req_ready, m_data, m_valid, credit_cnt, cred_ovf
   );
   modport slave (
      input  req_data, req_valid, req_last, m_credit,
      output req_ready, m_data, m_valid, credit_cnt, cred_ovf
   );
endinterface

// File: rtl/vc_credit_arbiter.sv
// vc_credit_arbiter: packet-atomic round-robin arbiter feeding a credit-controlled valid link
module vc_credit_arbiter #(
   parameter int N_REQ      = 4,
   parameter int DATA_WIDTH = 8,
   parameter int CREDIT_NUM = 2
) (
   input logic               clk,
   input logic               rst_n,
   vc_credit_arbiter_if.slave bus
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(CREDIT_NUM + 1);
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t                state;
   logic [IW-1:0]         ptr, lock_idx, scan, j, w;
   logic [CW-1:0]         cnt;
   logic                  found, send;
   logic [DATA_WIDTH-1:0] data_arr [N_REQ];
   for (genvar g = 0; g < N_REQ; g++) begin : g_data
      assign data_arr[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end
   always_comb begin
      scan  = ptr;
      found = 1'b0;
      j     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         j = IW'((int'(ptr) + k) % N_REQ);
         if (!found && bus.req_valid[j]) begin
            scan  = j;
            found = 1'b1;
         end
      end
   end
   assign w              = state == LOCKED ? lock_idx : scan;
   assign send           = cnt != '0 && bus.req_valid[w];
   assign bus.req_ready  = send ? N_REQ'(1) << w : '0;
   assign bus.credit_cnt = cnt;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= '0;
         lock_idx    <= '0;
         cnt         <= CW'(CREDIT_NUM);
         bus.cred_ovf <= 1'b0;
         bus.m_valid <= 1'b0;
         bus.m_data  <= '0;
      end else begin
         bus.m_valid <= send;
         if (send) begin
            bus.m_data <= data_arr[w];
            ptr        <= w == IW'(N_REQ - 1) ? '0 : w + 1'b1;
            lock_idx   <= w;
            state      <= bus.req_last[w] ? IDLE : LOCKED;
         end
         // a credit returned with every slot already held is a protocol error: saturate and flag
         if (bus.m_credit && !send && cnt == CW'(CREDIT_NUM)) bus.cred_ovf <= 1'b1;
         else cnt <= cnt - CW'(send) + CW'(bus.m_credit);
      end
   end
endmodule

// File: tb/tb_vc_credit_arbiter.sv
// tb_vc_credit_arbiter: table vectors, corner sequences and random traffic against a behavioural model
module tb_vc_credit_arbiter;
   localparam int N  = 4;
   localparam int CN = 2;
   localparam logic [31:0] D = 32'hA3A2A1A0;
   typedef struct {
      logic [3:0] v, l;
      logic       cr;
      logic [3:0] rdy;
      logic       mv;
      logic [7:0] dat;
      logic [1:0] cnt;
      logic       ovf;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   int m_cnt, m_ptr, m_owner;
   logic m_ovf, m_mv;
   logic [7:0] m_data;
   logic [3:0] m_ready, rdy_seen;
   vec_t tbl[11];
   logic [3:0] sv[6], sl[6], srd[6];
   logic scr[6];
   vc_credit_arbiter_if #(.N_REQ(N), .DATA_WIDTH(8), .CREDIT_NUM(CN)) bus();
   vc_credit_arbiter #(.N_REQ(N), .DATA_WIDTH(8), .CREDIT_NUM(CN)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, a, e);
      end
   endtask
   task automatic check_outputs();
      chk("m_valid", 32'(bus.m_valid), 32'(m_mv));
      chk("m_data", 32'(bus.m_data), 32'(m_data));
      chk("credit_cnt", 32'(bus.credit_cnt), 32'(m_cnt));
      chk("cred_ovf", 32'(bus.cred_ovf), 32'(m_ovf));
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req_valid = '0;
      bus.req_last = '0;
      bus.m_credit = 1'b0;
      bus.req_data = '0;
      @(posedge clk);
      m_cnt = CN; m_ptr = 0; m_owner = -1; m_ovf = 1'b0; m_mv = 1'b0; m_data = '0;
      #1;
      check_outputs();
   endtask
   task automatic cycle(input logic [3:0] v, input logic [3:0] l, input logic cr, input logic [31:0] d);
      int w;
      @(negedge clk);
      rst_n = 1'b1;
      bus.req_valid = v;
      bus.req_last = l;
      bus.m_credit = cr;
      bus.req_data = d;
      #1;
      w = -1;
      if (m_owner >= 0) w = m_owner;
      else for (int k = 0; k < N; k++) if (w < 0 && v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      m_ready = (m_cnt > 0 && w >= 0 && v[w]) ? 4'(1 << w) : 4'b0;
      rdy_seen = bus.req_ready;
      chk("ready", 32'(rdy_seen), 32'(m_ready));
      @(posedge clk);
      if (m_ready != 0) begin
         m_data = d[w*8 +: 8];
         m_ptr = (w + 1) % N;
         m_owner = l[w] ? -1 : w;
      end
      m_mv = m_ready != 0;
      if (cr && m_ready == 0 && m_cnt == CN) m_ovf = 1'b1;
      else m_cnt = m_cnt - int'(m_ready != 0) + int'(cr);
      #1;
      check_outputs();
   endtask
   initial begin
      tbl[0]  = '{4'hF, 4'hF, 1'b0, 4'b0001, 1'b1, 8'hA0, 2'd1, 1'b0};
      tbl[1]  = '{4'hF, 4'hF, 1'b0, 4'b0010, 1'b1, 8'hA1, 2'd0, 1'b0};
      tbl[2]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 8'hA1, 2'd1, 1'b0};
      tbl[3]  = '{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd1, 1'b0};
      tbl[4]  = '{4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd1, 1'b0};
      tbl[5]  = '{4'hF, 4'hF, 1'b0, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b0};
      tbl[6]  = '{4'hF, 4'hF, 1'b0, 4'b0000, 1'b0, 8'hA0, 2'd0, 1'b0};
      tbl[7]  = '{4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 8'hA0, 2'd1, 1'b0};
      tbl[8]  = '{4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 8'hA0, 2'd2, 1'b0};
      tbl[9]  = '{4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 8'hA0, 2'd2, 1'b1};
      tbl[10] = '{4'h0, 4'h0, 1'b0, 4'b0000, 1'b0, 8'hA0, 2'd2, 1'b1};
      sv  = '{4'b0010, 4'b1111, 4'b1011, 4'b1111, 4'b1111, 4'b1011};
      sl  = '{4'b0010, 4'b1011, 4'b1011, 4'b1011, 4'b1111, 4'b1111};
      scr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      srd = '{4'b0010, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b1000};
      bus.req_valid = '0;
      bus.req_last = '0;
      bus.m_credit = 1'b0;
      bus.req_data = '0;
      do_reset();
      for (int i = 0; i < 11; i++) begin
         cycle(tbl[i].v, tbl[i].l, tbl[i].cr, D);
         chk($sformatf("tbl%0d_ready", i), 32'(rdy_seen), 32'(tbl[i].rdy));
         chk($sformatf("tbl%0d_m_valid", i), 32'(bus.m_valid), 32'(tbl[i].mv));
         chk($sformatf("tbl%0d_m_data", i), 32'(bus.m_data), 32'(tbl[i].dat));
         chk($sformatf("tbl%0d_cnt", i), 32'(bus.credit_cnt), 32'(tbl[i].cnt));
         chk($sformatf("tbl%0d_ovf", i), 32'(bus.cred_ovf), 32'(tbl[i].ovf));
      end
      cycle(4'b0010, 4'b0000, 1'b0, D);
      chk("lock1_grant", 32'(rdy_seen), 32'b0010);
      cycle(4'b0011, 4'b0000, 1'b0, D);
      chk("lock1_hold", 32'(rdy_seen), 32'b0010);
      chk("lock1_cnt0", 32'(bus.credit_cnt), 32'd0);
      cycle(4'b0011, 4'b0000, 1'b0, D);
      chk("lock1_nocredit", 32'(rdy_seen), 32'b0000);
      do_reset();
      chk("rst_cnt", 32'(bus.credit_cnt), 32'd2);
      chk("rst_ovf", 32'(bus.cred_ovf), 32'd0);
      chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
      cycle(4'b0011, 4'b0011, 1'b0, D);
      chk("rst_req0_wins", 32'(rdy_seen), 32'b0001);
      do_reset();
      for (int i = 0; i < 6; i++) begin
         cycle(sv[i], sl[i], scr[i], D);
         chk($sformatf("pkt%0d_ready", i), 32'(rdy_seen), 32'(srd[i]));
      end
      chk("pkt_cnt", 32'(bus.credit_cnt), 32'd0);
      chk("pkt_data", 32'(bus.m_data), 32'hA3);
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(99) == 0) do_reset();
         cycle(4'($urandom), 4'($urandom & $urandom), $urandom_range(2) == 0, $urandom);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
